// File: rtl/speed_ramp_pkg.sv
// Shared types and helpers for the trapezoidal speed-ramp sequencer.
package speed_ramp_pkg;

    localparam int SPEED_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEL  = 2'd1,
        ST_CRUISE = 2'd2,
        ST_DECEL  = 2'd3
    } state_t;

    // Sum is formed one bit wider so it can never wrap before clamping.
    function automatic logic [SPEED_W-1:0] sat_add(input logic [SPEED_W-1:0] a,
                                                   input logic [SPEED_W-1:0] b,
                                                   input logic [SPEED_W-1:0] lim);
        logic [SPEED_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum >= {1'b0, lim}) ? lim : sum[SPEED_W-1:0];
    endfunction

    function automatic logic [SPEED_W-1:0] sat_sub(input logic [SPEED_W-1:0] a,
                                                   input logic [SPEED_W-1:0] b,
                                                   input logic [SPEED_W-1:0] lo);
        logic [SPEED_W-1:0] diff;
        diff = a - b;
        return ((a < b) || (diff < lo)) ? lo : diff;
    endfunction

    function automatic logic [SPEED_W-1:0] min_speed(input logic [SPEED_W-1:0] a,
                                                     input logic [SPEED_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/speed_tick_gen.sv
// Speed-update prescaler: one-cycle tick every TICK_DIV clocks, restartable by i_clr.
module speed_tick_gen #(
    parameter int TICK_DIV = 20000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    output logic o_tick
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    assign o_tick = (r_cnt == LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_cnt <= '0;
        else if (i_clr || o_tick)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + CNT_W'(1);
    end

endmodule

// File: rtl/speed_ramp_ctrl.sv
// Trapezoidal speed-profile sequencer feeding a speed_clk generator.
// Define SPEED_RAMP_SOFT_ABORT_EN to make abort ramp down instead of stopping at once.
module speed_ramp_ctrl
    import speed_ramp_pkg::*;
#(
    parameter int XTAL_CLK = 20000000,
    parameter int TICK_DIV = 20000,
    parameter int STEP_W   = 16
) (
    input  logic               sys_clk,
    input  logic               sys_rst_l,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [SPEED_W-1:0] cmd_speed,
    input  logic [SPEED_W-1:0] cmd_accel,
    input  logic [STEP_W-1:0]  cmd_steps,
    input  logic               abort,
    input  logic               step_pulse,
    output logic [SPEED_W-1:0] speed,
    output logic               change_readyH,
    output logic [SPEED_W-1:0] accelerate,
    output logic               run,
    output logic               done,
    output logic [1:0]         state
);

    state_t             r_state, w_state_next, w_eff_state;
    logic [SPEED_W-1:0] r_speed, w_speed_next, r_accel, w_accel_next;
    logic [SPEED_W-1:0] r_target, w_target_next, r_floor, w_floor_next;
    logic [STEP_W-1:0]  r_remaining, w_remaining_next, r_ramp_steps, w_ramp_next;
    logic               r_run, w_run_next, r_done, w_done_next, r_change, w_change_next;
    logic               r_abort_req, w_abort_next;
    logic               w_accept, w_tick, w_end;

    assign cmd_ready = (r_state == ST_IDLE) && !abort;
    assign w_accept  = cmd_valid && cmd_ready;

    // A nonsensical clock/divider pairing leaves the ramp frozen rather than ticking wildly.
    if (XTAL_CLK > 0 && TICK_DIV >= 2) begin : g_tick
        speed_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
            .i_clk   (sys_clk),
            .i_rst_n (sys_rst_l),
            .i_clr   (w_accept),
            .o_tick  (w_tick)
        );
    end else begin : g_no_tick
        assign w_tick = 1'b0;
    end

    always_comb begin
        w_state_next     = r_state;
        w_eff_state      = r_state;
        w_speed_next     = r_speed;
        w_accel_next     = r_accel;
        w_target_next    = r_target;
        w_floor_next     = r_floor;
        w_remaining_next = r_remaining;
        w_ramp_next      = r_ramp_steps;
        w_run_next       = r_run;
        w_done_next      = 1'b0;
        w_abort_next     = r_abort_req;
        w_end            = 1'b0;

        if (r_state == ST_IDLE) begin
            if (w_accept) begin
                w_accel_next     = cmd_accel;
                w_target_next    = cmd_speed;
                w_floor_next     = min_speed(cmd_accel, cmd_speed);
                w_remaining_next = cmd_steps;
                w_ramp_next      = '0;
                w_abort_next     = 1'b0;
                if (cmd_steps == '0 || cmd_speed == '0) begin
                    w_done_next = 1'b1;
                end else if (cmd_accel == '0) begin
                    w_speed_next = cmd_speed;
                    w_state_next = ST_CRUISE;
                    w_run_next   = 1'b1;
                end else begin
                    w_speed_next = min_speed(cmd_accel, cmd_speed);
                    w_state_next = ST_ACCEL;
                    w_run_next   = 1'b1;
                end
            end
        end else begin
            // Count the step first so the tick and decel test see fresh counts.
            if (step_pulse) begin
                w_remaining_next = (r_remaining != '0) ? r_remaining - STEP_W'(1) : '0;
                if (r_state == ST_ACCEL && !(&r_ramp_steps))
                    w_ramp_next = r_ramp_steps + STEP_W'(1);
            end
`ifdef SPEED_RAMP_SOFT_ABORT_EN
            if (abort)
                w_abort_next = 1'b1;
            w_end = (w_remaining_next == '0);
`else
            w_end = (w_remaining_next == '0) || abort;
`endif
            if (r_state != ST_DECEL && (w_remaining_next <= w_ramp_next || w_abort_next))
                w_eff_state = ST_DECEL;
            if (w_tick && w_eff_state == ST_DECEL && w_abort_next && r_speed == r_floor)
                w_end = 1'b1;

            if (w_end) begin
                w_speed_next = '0;
                w_state_next = ST_IDLE;
                w_run_next   = 1'b0;
                w_done_next  = 1'b1;
                w_abort_next = 1'b0;
            end else begin
                w_state_next = w_eff_state;
                if (w_tick) begin
                    case (w_eff_state)
                        ST_ACCEL: w_speed_next = sat_add(r_speed, r_accel, r_target);
                        ST_DECEL: w_speed_next = sat_sub(r_speed, r_accel, r_floor);
                        default:  w_speed_next = r_speed;
                    endcase
                end
                if (w_eff_state == ST_ACCEL && w_speed_next == r_target)
                    w_state_next = ST_CRUISE;
            end
        end

        w_change_next = (w_speed_next != r_speed);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            r_state      <= ST_IDLE;
            r_speed      <= '0;
            r_accel      <= '0;
            r_target     <= '0;
            r_floor      <= '0;
            r_remaining  <= '0;
            r_ramp_steps <= '0;
            r_run        <= 1'b0;
            r_done       <= 1'b0;
            r_change     <= 1'b0;
            r_abort_req  <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_speed      <= w_speed_next;
            r_accel      <= w_accel_next;
            r_target     <= w_target_next;
            r_floor      <= w_floor_next;
            r_remaining  <= w_remaining_next;
            r_ramp_steps <= w_ramp_next;
            r_run        <= w_run_next;
            r_done       <= w_done_next;
            r_change     <= w_change_next;
            r_abort_req  <= w_abort_next;
        end
    end

    assign speed         = r_speed;
    assign accelerate    = r_accel;
    assign change_readyH = r_change;
    assign run           = r_run;
    assign done          = r_done;
    assign state         = r_state;

endmodule

// File: tb/tb_speed_ramp_ctrl.sv
// Table-driven bench for speed_ramp_ctrl: expected speed strobes are queued per move and
// matched as the DUT emits them; edge counts of DECEL entry and done are checked per move.
module tb_speed_ramp_ctrl;

    localparam logic [1:0] S_IDLE = 2'd0, S_ACC = 2'd1, S_CRU = 2'd2, S_DEC = 2'd3;
    localparam logic [15:0] NONE = 16'hFFFF;

    logic        sys_clk = 1'b0;
    logic        sys_rst_l = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_speed = '0;
    logic [7:0]  cmd_accel = '0;
    logic [15:0] cmd_steps = '0;
    logic        abort = 1'b0;
    logic        step_pulse = 1'b0;
    logic [7:0]  speed;
    logic        change_readyH;
    logic [7:0]  accelerate;
    logic        run;
    logic        done;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;

    speed_ramp_ctrl #(.TICK_DIV(8)) dut (
        .sys_clk       (sys_clk),
        .sys_rst_l     (sys_rst_l),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_speed     (cmd_speed),
        .cmd_accel     (cmd_accel),
        .cmd_steps     (cmd_steps),
        .abort         (abort),
        .step_pulse    (step_pulse),
        .speed         (speed),
        .change_readyH (change_readyH),
        .accelerate    (accelerate),
        .run           (run),
        .done          (done),
        .state         (state)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic [7:0] spd;
        logic [1:0] st;
    } ev_t;

    typedef struct packed {
        logic [7:0]       spd;
        logic [7:0]       acc;
        logic [15:0]      steps;
        logic [7:0]       period;
        logic [15:0]      abort_at;
        logic [15:0]      done_edge;
        logic [15:0]      decel_edge;
        logic [3:0]       n_ev;
        logic [7:0][7:0]  ev_spd;
        logic [7:0][1:0]  ev_st;
    } vec_t;

    vec_t vecs [8];
    ev_t  exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Scoreboard: every speed strobe or done pulse consumes one queued expectation.
    always @(negedge sys_clk) begin
        ev_t e;
        if (sys_rst_l && (change_readyH || done)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event actual speed=%0d state=%0d done=%0b required none",
                         speed, state, done);
            end else begin
                e = exp_q.pop_front();
                if (speed !== e.spd || state !== e.st || done !== (e.st == S_IDLE)) begin
                    errors++;
                    $display("FAIL event actual speed=%0d state=%0d done=%0b required speed=%0d state=%0d done=%0b",
                             speed, state, done, e.spd, e.st, (e.st == S_IDLE));
                end else begin
                    $display("event speed=%0d state=%0d done=%0b ok", speed, state, done);
                end
            end
        end
    end

    function automatic vec_t mk(input logic [7:0] s, input logic [7:0] a, input logic [15:0] n,
                                input logic [7:0] p, input logic [15:0] ab,
                                input logic [15:0] dn, input logic [15:0] dc);
        vec_t t;
        t = '0;
        t.spd = s; t.acc = a; t.steps = n; t.period = p;
        t.abort_at = ab; t.done_edge = dn; t.decel_edge = dc;
        return t;
    endfunction

    task automatic add_ev(input int v, input logic [7:0] s, input logic [1:0] st);
        vecs[v].ev_spd[vecs[v].n_ev] = s;
        vecs[v].ev_st[vecs[v].n_ev]  = st;
        vecs[v].n_ev = vecs[v].n_ev + 4'd1;
    endtask

    // Called just after a negedge; returns just after the negedge following done.
    task automatic apply_vec(input int v);
        vec_t t;
        ev_t  e;
        int   cnt;
        int   got;
        int   first_dec;
        logic degen;
        t = vecs[v];
        degen = (t.steps == 0 || t.spd == 0);
        for (int i = 0; i < int'(t.n_ev); i++) begin
            e.spd = t.ev_spd[i];
            e.st  = t.ev_st[i];
            exp_q.push_back(e);
        end
        cmd_speed = t.spd;
        cmd_accel = t.acc;
        cmd_steps = t.steps;
        cmd_valid = 1'b1;
        @(negedge sys_clk);
        cmd_valid = 1'b0;
        chk($sformatf("v%0d_accept_run", v), {31'd0, run}, {31'd0, !degen});
        chk($sformatf("v%0d_accept_done", v), {31'd0, done}, {31'd0, degen});
        cnt = 0;
        got = -1;
        first_dec = -1;
        while (cnt < 2000) begin
            if (state == S_DEC && first_dec < 0)
                first_dec = cnt;
            if (done) begin
                got = cnt;
                break;
            end
            cnt++;
            step_pulse = ((cnt % int'(t.period)) == 0);
            abort      = (cnt == int'(t.abort_at));
            @(negedge sys_clk);
        end
        step_pulse = 1'b0;
        abort = 1'b0;
        chk($sformatf("v%0d_done_edge", v), got, int'(t.done_edge));
        chk($sformatf("v%0d_decel_edge", v), first_dec,
            (t.decel_edge == NONE) ? -1 : int'(t.decel_edge));
        #1;
        chk($sformatf("v%0d_idle_after", v), {30'd0, run, cmd_ready}, 32'd1);
        chk($sformatf("v%0d_events_left", v), exp_q.size(), 0);
        exp_q.delete();
        $display("move %0d speed=%0d accel=%0d steps=%0d done_edge=%0d decel_edge=%0d",
                 v, t.spd, t.acc, t.steps, got, first_dec);
    endtask

    initial begin
        // Ramp profile; decel entry at 776 coincides with a tick (collision case).
        vecs[0] = mk(8'd40, 8'd10, 16'd200, 8'd4, 16'd0, 16'd800, 16'd776);
        add_ev(0, 8'd10, S_ACC); add_ev(0, 8'd20, S_ACC); add_ev(0, 8'd30, S_ACC);
        add_ev(0, 8'd40, S_CRU); add_ev(0, 8'd30, S_DEC); add_ev(0, 8'd20, S_DEC);
        add_ev(0, 8'd10, S_DEC); add_ev(0, 8'd0, S_IDLE);
        // Short move never reaches target.
        vecs[1] = mk(8'd200, 8'd10, 16'd6, 8'd4, 16'd0, 16'd24, 16'd12);
        add_ev(1, 8'd10, S_ACC); add_ev(1, 8'd20, S_ACC); add_ev(1, 8'd10, S_DEC);
        add_ev(1, 8'd0, S_IDLE);
        vecs[2] = mk(8'd40, 8'd10, 16'd0, 8'd4, 16'd0, 16'd0, NONE);
        add_ev(2, 8'd0, S_IDLE);
        vecs[3] = mk(8'd50, 8'd0, 16'd4, 8'd4, 16'd0, 16'd16, NONE);
        add_ev(3, 8'd50, S_CRU); add_ev(3, 8'd0, S_IDLE);
`ifdef SPEED_RAMP_SOFT_ABORT_EN
        vecs[4] = mk(8'd40, 8'd10, 16'd200, 8'd4, 16'd100, 16'd128, 16'd100);
        add_ev(4, 8'd10, S_ACC); add_ev(4, 8'd20, S_ACC); add_ev(4, 8'd30, S_ACC);
        add_ev(4, 8'd40, S_CRU); add_ev(4, 8'd30, S_DEC); add_ev(4, 8'd20, S_DEC);
        add_ev(4, 8'd10, S_DEC); add_ev(4, 8'd0, S_IDLE);
`else
        vecs[4] = mk(8'd40, 8'd10, 16'd200, 8'd4, 16'd100, 16'd100, NONE);
        add_ev(4, 8'd10, S_ACC); add_ev(4, 8'd20, S_ACC); add_ev(4, 8'd30, S_ACC);
        add_ev(4, 8'd40, S_CRU); add_ev(4, 8'd0, S_IDLE);
`endif
        vecs[5] = mk(8'd0, 8'd10, 16'd5, 8'd4, 16'd0, 16'd0, NONE);
        add_ev(5, 8'd0, S_IDLE);
        // Accel larger than target: floor equals target, no ramp.
        vecs[6] = mk(8'd30, 8'd50, 16'd10, 8'd4, 16'd0, 16'd40, NONE);
        add_ev(6, 8'd30, S_ACC); add_ev(6, 8'd0, S_IDLE);
        // Fresh move after the mid-ACCEL reset.
        vecs[7] = mk(8'd20, 8'd10, 16'd8, 8'd4, 16'd0, 16'd32, 16'd24);
        add_ev(7, 8'd10, S_ACC); add_ev(7, 8'd20, S_CRU); add_ev(7, 8'd10, S_DEC);
        add_ev(7, 8'd0, S_IDLE);

        repeat (2) @(negedge sys_clk);
        chk("reset_outputs", {speed, accelerate, change_readyH, run, done, cmd_ready, state},
            {8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0});
        sys_rst_l = 1'b1;
        @(negedge sys_clk);

        for (int v = 0; v < 7; v++)
            apply_vec(v);

        // Asynchronous reset in the middle of ACCEL.
        begin
            ev_t e;
            e.spd = 8'd10;
            e.st  = S_ACC;
            exp_q.push_back(e);
        end
        cmd_speed = 8'd40;
        cmd_accel = 8'd10;
        cmd_steps = 16'd200;
        cmd_valid = 1'b1;
        @(negedge sys_clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge sys_clk);
        chk("pre_reset_state", {30'd0, state}, {30'd0, S_ACC});
        #2 sys_rst_l = 1'b0;
        #1;
        chk("async_reset_speed", {24'd0, speed}, 32'd0);
        chk("async_reset_accel", {24'd0, accelerate}, 32'd0);
        chk("async_reset_flags", {27'd0, change_readyH, run, done, cmd_ready, (state == S_IDLE)},
            32'd3);
        chk("reset_events_left", exp_q.size(), 0);
        exp_q.delete();
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst_l = 1'b1;
        #1;
        apply_vec(7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/speed_ramp_ctrl.md
# speed_ramp_ctrl

Trapezoidal speed-profile sequencer that drives the `speed_clk` pulse generator. It accepts one move command (target speed, acceleration, step count) and ramps the `speed` setting up, holds it, then ramps it down so the last step lands at floor speed. It counts the generator's emitted steps to decide when deceleration starts. It sits between the interpolation core (command side) and one per-axis `speed_clk` instance (datapath side).

## Interface
- `XTAL_CLK`, default 20000000: system clock frequency in Hz (documentation and tick derivation only).
- `TICK_DIV`, default 20000: number of `sys_clk` cycles per speed-update tick (1 ms at 20 MHz); must be ≥ 2.
- `STEP_W`, default 16: width of the step counters.
- `sys_clk` in 1: main clock. One clock domain only.
- `sys_rst_l` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: move command valid.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_speed` in 8: target speed code.
- `cmd_accel` in 8: speed increment or decrement per tick.
- `cmd_steps` in STEP_W: steps to move.
- `abort` in 1: level; sampled every cycle while running.
- `step_pulse` in 1: one-cycle strobe per step emitted by the generator, synchronous to `sys_clk`.
- `speed` out 8: speed code to the generator.
- `change_readyH` out 1: one-cycle strobe; generator reloads `speed`/`accelerate`.
- `accelerate` out 8: latched `cmd_accel` to the generator.
- `run` out 1: move in progress.
- `done` out 1: one-cycle strobe at move end.
- `state` out 2: 0 IDLE, 1 ACCEL, 2 CRUISE, 3 DECEL.

## Operation
- Reset values: `speed`=0, `accelerate`=0, `change_readyH`=0, `run`=0, `done`=0, `cmd_ready`=1, state IDLE. All counters are 0.
- Accept on `cmd_valid & cmd_ready`. On accept:
  - Latch the command.
  - Set `remaining`=`cmd_steps` and `ramp_steps`=0.
  - Clear the tick prescaler.
- Degenerate commands:
  - `cmd_steps`=0 or `cmd_speed`=0: go straight to IDLE with `done`. No `speed` change and no `run`.
  - `cmd_accel`=0: `speed`=`cmd_speed` immediately, then CRUISE. There is no ramp. The deceleration test below still runs, with `ramp_steps`=0.
- Floor speed is `floor` = min(`cmd_accel`, `cmd_speed`). Entering ACCEL sets `speed`=`floor`.
- Each `step_pulse` while `run` decrements `remaining`, saturating at 0. In ACCEL it also increments `ramp_steps`, saturating.
- ACCEL, on each tick: `speed` = min(`speed`+`accel`, target). The sum is 9 bits and cannot wrap. Go to CRUISE when `speed` reaches target.
- Deceleration test: in ACCEL or CRUISE, when `remaining` ≤ `ramp_steps`, go to DECEL. This test takes priority over ACCEL→CRUISE in the same cycle.
- DECEL, on each tick: `speed` = max(`speed`−`accel`, `floor`). There is no underflow.
- Move end: `remaining` reaches 0 in any running state. Then:
  - `speed`=0 and `change_readyH`, both in the same cycle.
  - `done`, `run`=0, state IDLE.
- Every change of `speed` pulses `change_readyH` in the cycle `speed` takes its new value. No strobe is issued when a tick leaves `speed` unchanged.
- Simultaneous `step_pulse` and tick: the step is counted first, and the tick update and deceleration test use the updated counts.
- `abort` while running: see Configuration. `abort` in IDLE is ignored, and it blocks accept while high.

## Timing
- Accept at edge N produces, at N+1: `run`=1, `speed`=`floor`, `change_readyH`=1, state ACCEL.
- The first tick occurs `TICK_DIV` cycles after accept. Later ticks follow every `TICK_DIV` cycles.
- A `step_pulse` at edge M that zeroes `remaining` produces, at M+1: `done`, `speed`=0, `change_readyH`=1, `cmd_ready`=1.
- A new command can be accepted at M+1. It then takes effect at M+2.
- Asynchronous reset mid-move forces all outputs to their reset values immediately. No `done` is issued.

## Configuration
- `SPEED_RAMP_SOFT_ABORT_EN` defined: `abort` forces DECEL from ACCEL or CRUISE. When `speed` equals `floor` on a tick, the move ends as above, with `done`.
- Not defined: `abort` ends the move on the next edge. This means `speed`=0, `change_readyH`, `done`, and IDLE in one cycle.

## Structure
- Package `speed_ramp_pkg` holds:
  - the state enum (IDLE/ACCEL/CRUISE/DECEL, 2 bits);
  - the `SPEED_W`=8 constant;
  - saturating add/subtract helper functions.
- Sub-module `speed_tick_gen` is a `TICK_DIV` prescaler. It has a synchronous clear and a one-cycle `tick` output.

## Test plan
- Ramp profile: speed=40, accel=10, steps=200, steps at fixed rate. Required sequence:
  - `speed` 10→20→30→40 on successive ticks;
  - CRUISE;
  - DECEL when `remaining` ≤ `ramp_steps`;
  - steps down to 10;
  - `done` after the 200th step.
- Short move: speed=200, accel=10, steps=6. DECEL is entered before target is reached, and `speed` never exceeds the peak mirror of the ramp.
- Degenerate commands:
  - steps=0: `done` the cycle after accept, `run` stays 0;
  - accel=0: `speed` jumps to target with a single strobe.
- Collision: `step_pulse` and tick in the same cycle, with `remaining`=`ramp_steps`+1. DECEL is entered and the tick applies the decrement.
- Abort mid-CRUISE at speed 40, accel 10, once per macro setting:
  - with macro: ramp 30→20→10, then `done`;
  - without macro: `speed`=0 and `done` on the next edge.
- Reset: assert `sys_rst_l`=0 mid-ACCEL. All outputs go to reset values asynchronously, and a fresh command after release runs normally.
